// File: rtl/gate_op_scheduler.sv
// Time-multiplexes one 1-bit NAND/NOR/XOR gate between two requesters.
// Operands are evaluated LSB first, one bit per clock, with round-robin arbitration.
module gate_op_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             res_err,
  output logic             busy
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             id_q, id_d;
  logic             err_q, err_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       ready_c;
  logic             grant;

  function automatic logic gate_bit(input logic [1:0] op, input logic a, input logic b);
    case (op)
      2'b00:   return ~(a & b);
      2'b01:   return ~(a | b);
      2'b10:   return a ^ b;
      default: return 1'b0;
    endcase
  endfunction

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    idx_d        = idx_q;
    id_d         = id_q;
    err_d        = err_q;
    last_grant_d = last_grant_q;
    ready_c      = 2'b00;
    grant        = 1'b0;

    case (state_q)
      IDLE: begin
        case (req_valid)
          2'b01:   begin grant = 1'b0;          ready_c = 2'b01; end
          2'b10:   begin grant = 1'b1;          ready_c = 2'b10; end
          2'b11:   begin grant = ~last_grant_q; ready_c = grant ? 2'b10 : 2'b01; end
          default: begin grant = 1'b0;          ready_c = 2'b00; end
        endcase
        if (|(req_valid & ready_c)) begin
          op_d         = grant ? req_op1 : req_op0;
          a_d          = grant ? req_a1  : req_a0;
          b_d          = grant ? req_b1  : req_b0;
          id_d         = grant;
          last_grant_d = grant;
          res_d        = '0;
          err_d        = 1'b0;
          idx_d        = '0;
          state_d      = RUN;
        end
      end
      RUN: begin
        res_d[idx_q] = gate_bit(op_q, a_q[idx_q], b_q[idx_q]);
        if (op_q == 2'b11) err_d = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= 2'b00;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      idx_q        <= '0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      idx_q        <= idx_d;
      id_q         <= id_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Handshake outputs are forced quiet during the reset cycle itself, whatever the state.
  assign req_ready = rst_n ? ready_c : 2'b00;
  assign res_valid = rst_n & (state_q == DONE);
  assign busy      = rst_n & (state_q != IDLE);
  assign res_data  = res_q;
  assign res_id    = id_q;
  assign res_err   = err_q;

endmodule

// File: doc/gate_op_scheduler.md
# gate_op_scheduler

Shares one 1-bit NAND/NOR/XOR gate unit between two requesters and evaluates WIDTH-bit operand pairs serially, one bit per clock. Each requester has a valid/ready command port. A round-robin arbiter grants the shared unit, and a single result port with valid/ready backpressure returns the result. The block sits in front of the team's combinational gate primitive and turns it into a time-multiplexed, handshaked resource.

## Interface
- WIDTH, 8: operand/result width in bits (≥2).
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset. Sampled on the clk rising edge.
- req_valid  input  2  per-requester command valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept; at most one bit high.
- req_op0, req_op1  input  2 each  operation: 00 NAND, 01 NOR, 10 XOR, 11 illegal.
- req_a0, req_b0, req_a1, req_b1  input  WIDTH each  operands.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  WIDTH  result bits.
- res_id  output  1  index of the requester that owns the result.
- res_err  output  1  high with res_valid when the op was illegal.
- busy  output  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: combinational grant.
  - Only one req_valid bit high: that requester is granted.
  - Both high: the requester not equal to last_grant is granted.
  - The granted bit of req_ready is 1. req_ready = 00 outside IDLE.
- Accept = req_valid[g] & req_ready[g] at a clock edge. On accept:
  - latch op, a, b of requester g; latch id = g; set last_grant = g;
  - clear result register; bit index = 0; go to RUN.
- RUN: each edge computes result[idx] = gate(op, a[idx], b[idx]), LSB first.
  - gate: NAND ~(a&b), NOR ~(a|b), XOR a^b.
  - Illegal op: result bit 0 and error flag set.
  - idx increments by 1 per edge. After the edge that processes idx = WIDTH-1, go to DONE.
- DONE: res_valid = 1, with res_data, res_id and res_err held stable.
  - On the edge with res_ready = 1, go to IDLE.
  - No new command is accepted in that same cycle.
- res_data, res_id and res_err are only meaningful while res_valid = 1. They hold their last values otherwise.
- Operands are sampled only at accept. Input changes afterwards do not affect the result in flight.
- A requester dropping req_valid before accept is legal; no state changes.

## Timing
- Reset (rst_n = 0 at an edge) forces, regardless of state:
  - FSM to IDLE; last_grant = 1, so requester 0 wins the first contention;
  - idx = 0; res_data = 0; res_id = 0; res_err = 0.
  - res_valid = 0, busy = 0 and req_ready = 00 during the reset cycle.
- Reset mid-RUN or mid-DONE aborts the command. No res_valid is produced for it.
- Latency: accept at edge k. Bits are evaluated at edges k+1 … k+WIDTH. res_valid is high from edge k+WIDTH until the res_ready edge.
- Minimum command spacing (res_ready tied high) is WIDTH+2 cycles: accept, WIDTH RUN edges, DONE edge, then IDLE.
- res_ready low holds DONE indefinitely. Both req_ready bits stay 0 meanwhile.
- Simultaneous req_valid = 11 in IDLE: exactly one grant. Across successive contended commands, grants alternate 0,1,0,1.
- busy is 1 from the cycle after accept through the DONE cycle inclusive.

## Test plan
- Reset, then requester 0: op = 00, a = 8'hF0, b = 8'hCC.
  - Required: res_data = 8'h3F, res_id = 0, res_err = 0.
  - res_valid first high 8 edges after accept; busy = 1 throughout.
- Requester 1 alone: op = 01, a = 8'hF0, b = 8'hCC → res_data = 8'h03, res_id = 1. Then op = 10 → res_data = 8'h3C.
- Both requesters hold req_valid = 1 continuously for 4 commands, res_ready = 1.
  - Required: res_id sequence 0,1,0,1.
  - Accepts exactly 10 cycles apart.
  - req_ready never 11.
- Illegal op = 11, a = 8'hFF, b = 8'hFF → res_data = 8'h00, res_err = 1. A following legal XOR command returns res_err = 0.
- res_ready held 0 for 5 cycles in DONE.
  - Required: res_valid and res_data stable; req_ready = 00 despite req_valid = 11.
  - Release res_ready → IDLE next cycle.
- rst_n pulsed low at RUN idx = 3.
  - Required: next cycle res_valid = 0, busy = 0, state IDLE.
  - No stale result appears.
  - Next contended command grants requester 0.
